// File: rtl/hazard_pkg.sv
// Shared types and defaults for the non-forwarding hazard controller.
// Control bundle is purely combinational; no flow-control state lives here.
package hazard_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int NUM_REGS_DEF      = 32;
  localparam int CNT_W_DEF         = 2;
  localparam int PERF_W_DEF        = 32;
  localparam int STALL_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic id_issue;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, id_issue: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                   id_ex_flush: 1'b1, id_issue: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                   id_ex_flush: 1'b1, id_issue: 1'b0};

  function automatic ctrl_t ctrl_run(input logic id_vld);
    ctrl_t c;
    c.pc_en       = 1'b1;
    c.if_id_en    = 1'b1;
    c.if_id_flush = 1'b0;
    c.id_ex_flush = 1'b0;
    c.id_issue    = id_vld;
    return c;
  endfunction

endpackage

// File: rtl/reg_pend_tracker.sv
// Per-register count of writers issued past ID and not yet retired from WB.
// Reads are combinational on registered counts (no same-cycle WB bypass).
module reg_pend_tracker
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  inc_vld,
  input  logic [REG_ADDR_W-1:0] inc_addr,
  input  logic                  dec_vld,
  input  logic [REG_ADDR_W-1:0] dec_addr,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  output logic                  rd_a_busy,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  output logic                  rd_b_busy
);

  logic [CNT_W-1:0] pend [NUM_REGS];

  // x0 is hardwired, so it can never be waited on.
  assign pend[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    logic inc_hit;
    logic dec_hit;

    assign inc_hit = inc_vld && (inc_addr == REG_ADDR_W'(r));
    assign dec_hit = dec_vld && (dec_addr == REG_ADDR_W'(r));

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        pend[r] <= '0;
      end else if (inc_hit && !dec_hit) begin
        pend[r] <= pend[r] + CNT_W'(1);
      end else if (dec_hit && !inc_hit) begin
        pend[r] <= pend[r] - CNT_W'(1);
      end
    end
  end

  assign rd_a_busy = |pend[rd_a_addr];
  assign rd_b_busy = |pend[rd_b_addr];

endmodule

// File: rtl/hazard_ctrl_non_fwd.sv
// Stall/flush control for a 5-stage pipeline without forwarding; outputs are combinational on ID/EX inputs.
// RAW consumers wait until the producer leaves WB; mispredict overrides any stall.
module hazard_ctrl_non_fwd
  import hazard_pkg::*;
#(
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PERF_W        = PERF_W_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_id_vld,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic                  i_id_rs1_use,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs2_use,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_wb_vld,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic                  i_wb_rd_wren,
  input  logic                  i_ex_mispred,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_id_issue,
  output logic [1:0]            o_state,
  output logic [PERF_W-1:0]     o_stall_cnt,
  output logic [PERF_W-1:0]     o_flush_cnt,
  output logic                  o_deadlock
);

  localparam int RUN_W = $clog2(STALL_TIMEOUT + 1);

  state_e            state_q;
  state_e            state_d;
  ctrl_t             ctrl;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              hazard;
  logic              pend_inc;
  logic              pend_dec;
  logic              stall_evt;
  logic              flush_evt;
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;
  logic [RUN_W-1:0]  stall_run_q;
  logic              deadlock_q;

  // A killed ID instruction must not be counted; ctrl.id_issue is already 0 on mispredict.
  assign pend_inc = ctrl.id_issue && i_id_rd_wren && (i_id_rd_addr != '0);
  assign pend_dec = i_wb_vld && i_wb_rd_wren && (i_wb_rd_addr != '0);

  reg_pend_tracker #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_pend (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .inc_vld   (pend_inc),
    .inc_addr  (i_id_rd_addr),
    .dec_vld   (pend_dec),
    .dec_addr  (i_wb_rd_addr),
    .rd_a_addr (i_id_rs1_addr),
    .rd_a_busy (rs1_busy),
    .rd_b_addr (i_id_rs2_addr),
    .rd_b_busy (rs2_busy)
  );

  assign hazard = i_id_vld &&
                  ((i_id_rs1_use && (i_id_rs1_addr != '0) && rs1_busy) ||
                   (i_id_rs2_use && (i_id_rs2_addr != '0) && rs2_busy));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    ctrl    = ctrl_run(i_id_vld);
    if (i_ex_mispred) begin
      state_d = FLUSH;
      ctrl    = CTRL_FLUSH;
    end else if (hazard) begin
      state_d = STALL;
      ctrl    = CTRL_STALL;
    end
    // Hold the front end in a bubble state for as long as reset is asserted.
    if (!i_reset) begin
      ctrl = CTRL_RESET;
    end
  end

  assign stall_evt = (state_d == STALL);
  assign flush_evt = (state_d == FLUSH);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush_evt) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  // Run length saturates at the timeout so a very long stall cannot wrap it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_run_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      if (!stall_evt) begin
        stall_run_q <= '0;
      end else if (stall_run_q != RUN_W'(STALL_TIMEOUT)) begin
        stall_run_q <= stall_run_q + RUN_W'(1);
      end
      if (stall_evt && (stall_run_q == RUN_W'(STALL_TIMEOUT - 1))) begin
        deadlock_q <= 1'b1;
      end
    end
  end

  assign o_pc_en       = ctrl.pc_en;
  assign o_if_id_en    = ctrl.if_id_en;
  assign o_if_id_flush = ctrl.if_id_flush;
  assign o_id_ex_flush = ctrl.id_ex_flush;
  assign o_id_issue    = ctrl.id_issue;
  assign o_state       = state_q;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;
  assign o_deadlock    = deadlock_q;

endmodule

// File: tb/tb_hazard_ctrl_non_fwd.sv
// Directed and random checks of hazard_ctrl_non_fwd against a stage-occupancy pipeline model.
module tb_hazard_ctrl_non_fwd;

  localparam int TIMEOUT = 16;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_id_vld;
  logic [4:0]  i_id_rs1_addr;
  logic        i_id_rs1_use;
  logic [4:0]  i_id_rs2_addr;
  logic        i_id_rs2_use;
  logic [4:0]  i_id_rd_addr;
  logic        i_id_rd_wren;
  logic        i_wb_vld;
  logic [4:0]  i_wb_rd_addr;
  logic        i_wb_rd_wren;
  logic        i_ex_mispred;
  logic        o_pc_en;
  logic        o_if_id_en;
  logic        o_if_id_flush;
  logic        o_id_ex_flush;
  logic        o_id_issue;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;
  logic        o_deadlock;

  always #5 i_clk = ~i_clk;

  hazard_ctrl_non_fwd dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_id_vld      (i_id_vld),
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs1_use  (i_id_rs1_use),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_rs2_use  (i_id_rs2_use),
    .i_id_rd_addr  (i_id_rd_addr),
    .i_id_rd_wren  (i_id_rd_wren),
    .i_wb_vld      (i_wb_vld),
    .i_wb_rd_addr  (i_wb_rd_addr),
    .i_wb_rd_wren  (i_wb_rd_wren),
    .i_ex_mispred  (i_ex_mispred),
    .o_pc_en       (o_pc_en),
    .o_if_id_en    (o_if_id_en),
    .o_if_id_flush (o_if_id_flush),
    .o_id_ex_flush (o_id_ex_flush),
    .o_id_issue    (o_id_issue),
    .o_state       (o_state),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt),
    .o_deadlock    (o_deadlock)
  );

  // Pipeline model: slot 0 = EX, 1 = MEM, 2 = WB. A register is busy while any slot holds a writer of it.
  typedef struct {
    bit vld;
    bit wren;
    int rd;
  } slot_t;

  slot_t       pipe [3];
  bit          hold;
  int          checks   = 0;
  int          failures = 0;
  int unsigned m_stall;
  int unsigned m_flush;
  int          m_state;
  int          m_run;
  bit          m_dead;
  bit          m_issue;
  bit          m_mp;
  bit          obs_issue;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int writers_of(input int r);
    int n = 0;
    if (r == 0) return 0;
    for (int s = 0; s < 3; s++) if (pipe[s].vld && pipe[s].wren && pipe[s].rd == r) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{vld: 1'b0, wren: 1'b0, rd: 0};
    m_stall = 0;
    m_flush = 0;
    m_state = 0;
    m_run   = 0;
    m_dead  = 1'b0;
  endtask

  task automatic set_id(input bit vld, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit w);
    i_id_vld      = vld;
    i_id_rs1_addr = 5'(rs1);
    i_id_rs1_use  = u1;
    i_id_rs2_addr = 5'(rs2);
    i_id_rs2_use  = u2;
    i_id_rd_addr  = 5'(rd);
    i_id_rd_wren  = w;
  endtask

  // One clock: drive WB from the model, check at negedge, then advance the model at posedge.
  task automatic cycle();
    bit hz, mp, e_pc, e_ifen, e_iff, e_ief, e_iss;
    if (!hold && pipe[2].vld) begin
      i_wb_vld     = 1'b1;
      i_wb_rd_wren = pipe[2].wren;
      i_wb_rd_addr = 5'(pipe[2].rd);
    end else begin
      i_wb_vld     = 1'b0;
      i_wb_rd_wren = 1'b0;
      i_wb_rd_addr = 5'd0;
    end
    @(negedge i_clk);
    mp = i_ex_mispred;
    hz = i_id_vld && ((i_id_rs1_use && writers_of(int'(i_id_rs1_addr)) > 0) ||
                      (i_id_rs2_use && writers_of(int'(i_id_rs2_addr)) > 0));
    if (mp)      {e_pc, e_ifen, e_iff, e_ief, e_iss} = 5'b11110;
    else if (hz) {e_pc, e_ifen, e_iff, e_ief, e_iss} = 5'b00010;
    else         {e_pc, e_ifen, e_iff, e_ief, e_iss} = {4'b1100, i_id_vld};
    chk("pc_en",       64'(o_pc_en),       64'(e_pc));
    chk("if_id_en",    64'(o_if_id_en),    64'(e_ifen));
    chk("if_id_flush", 64'(o_if_id_flush), 64'(e_iff));
    chk("id_ex_flush", 64'(o_id_ex_flush), 64'(e_ief));
    chk("id_issue",    64'(o_id_issue),    64'(e_iss));
    chk("state",       64'(o_state),       64'(m_state));
    chk("stall_cnt",   64'(o_stall_cnt),   64'(m_stall));
    chk("flush_cnt",   64'(o_flush_cnt),   64'(m_flush));
    chk("deadlock",    64'(o_deadlock),    64'(m_dead));
    if (e_iss && i_id_rd_wren && i_id_rd_addr != 5'd0)
      chk("pend_inc_legal", 64'(writers_of(int'(i_id_rd_addr)) < 3), 64'd1);
    obs_issue = o_id_issue;
    @(posedge i_clk);
    if (mp) m_flush++;
    if (hz && !mp) begin
      m_stall++;
      m_run++;
      if (m_run >= TIMEOUT) m_dead = 1'b1;
    end else begin
      m_run = 0;
    end
    m_state = mp ? 2 : (hz ? 1 : 0);
    if (!hold) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{vld: e_iss, wren: i_id_rd_wren, rd: int'(i_id_rd_addr)};
    end
    m_issue = e_iss;
    m_mp    = mp;
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pc_en",       64'(o_pc_en),       64'd0);
      chk("rst_if_id_en",    64'(o_if_id_en),    64'd0);
      chk("rst_if_id_flush", 64'(o_if_id_flush), 64'd1);
      chk("rst_id_ex_flush", 64'(o_id_ex_flush), 64'd1);
      chk("rst_id_issue",    64'(o_id_issue),    64'd0);
      chk("rst_state",       64'(o_state),       64'd0);
      chk("rst_stall_cnt",   64'(o_stall_cnt),   64'd0);
      chk("rst_flush_cnt",   64'(o_flush_cnt),   64'd0);
      chk("rst_deadlock",    64'(o_deadlock),    64'd0);
      @(posedge i_clk);
      #1;
    end
    i_reset = 1'b1;
    model_clear();
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
  endtask

  task automatic wait_issue(input string tag, input int exp_stalls);
    int  stalls = 0;
    bit  issued = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (obs_issue) begin
        issued = 1'b1;
        break;
      end
      stalls++;
    end
    chk({tag, "_issued"}, 64'(issued), 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
  endtask

  initial begin
    hold         = 1'b0;
    i_ex_mispred = 1'b0;
    i_wb_vld     = 1'b0;
    i_wb_rd_addr = 5'd0;
    i_wb_rd_wren = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    do_reset();

    // Back-to-back RAW on x5: three stall cycles, issue on the fourth.
    set_id(1, 0, 0, 0, 0, 5, 1);
    cycle();
    chk("t1_prod_issue", 64'(obs_issue), 64'd1);
    set_id(1, 5, 1, 0, 1, 6, 1);
    wait_issue("t1", 3);
    chk("t1_stall_cnt", 64'(o_stall_cnt), 64'd3);
    drain();

    // x0 never blocks; an unused rs2 that is pending does not block.
    set_id(1, 0, 0, 0, 0, 0, 1);
    cycle();
    set_id(1, 0, 1, 0, 1, 3, 1);
    cycle();
    chk("t2_x0_issue", 64'(obs_issue), 64'd1);
    set_id(1, 0, 0, 0, 0, 4, 1);
    cycle();
    set_id(1, 0, 0, 4, 0, 8, 1);
    cycle();
    chk("t2_unused_issue", 64'(obs_issue), 64'd1);
    chk("t2_stall_cnt", 64'(o_stall_cnt), 64'd3);
    drain();

    // Mispredict while a consumer is stalled; the producer stays pending.
    set_id(1, 0, 0, 0, 0, 5, 1);
    cycle();
    set_id(1, 5, 1, 0, 0, 6, 1);
    cycle();
    chk("t3_stalled", 64'(obs_issue), 64'd0);
    i_ex_mispred = 1'b1;
    cycle();
    i_ex_mispred = 1'b0;
    chk("t3_state_flush", 64'(o_state), 64'd2);
    chk("t3_flush_cnt", 64'(o_flush_cnt), 64'd1);
    set_id(1, 5, 1, 0, 0, 6, 1);
    wait_issue("t3", 1);
    drain();

    // WAW: the reader waits for the second x7 writer to retire.
    set_id(1, 0, 0, 0, 0, 7, 1);
    cycle();
    cycle();
    set_id(1, 0, 0, 7, 1, 10, 1);
    wait_issue("t4_waw", 3);
    drain();
    // Issue of a new x7 writer in the same cycle the old one retires.
    set_id(1, 0, 0, 0, 0, 7, 1);
    cycle();
    set_id(1, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    set_id(1, 0, 0, 0, 0, 7, 1);
    cycle();
    set_id(1, 7, 1, 0, 0, 11, 1);
    wait_issue("t4_same", 3);
    drain();

    // Watchdog: x9 never retires while WB is held idle.
    set_id(1, 0, 0, 0, 0, 9, 1);
    cycle();
    hold = 1'b1;
    set_id(1, 9, 1, 0, 0, 12, 1);
    repeat (TIMEOUT - 1) cycle();
    chk("t5_not_yet", 64'(o_deadlock), 64'd0);
    repeat (4) cycle();
    chk("t5_deadlock", 64'(o_deadlock), 64'd1);
    hold = 1'b0;
    wait_issue("t5", 3);
    drain();
    chk("t5_sticky", 64'(o_deadlock), 64'd1);

    // Reset in the middle of a stall drops every pending entry.
    set_id(1, 0, 0, 0, 0, 3, 1);
    cycle();
    set_id(1, 3, 1, 3, 1, 13, 1);
    cycle();
    chk("t6_stalled", 64'(obs_issue), 64'd0);
    do_reset();
    cycle();
    chk("t6_issue_after_rst", 64'(obs_issue), 64'd1);
    drain();

    // Random traffic on a small register window so hazards are frequent.
    begin
      bit need_new = 1'b1;
      for (int n = 0; n < 600; n++) begin
        if (need_new)
          set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0);
        i_ex_mispred = ($urandom_range(0, 11) == 0);
        cycle();
        need_new = m_issue || m_mp || !i_id_vld;
      end
      i_ex_mispred = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_non_fwd.md
Name: hazard_ctrl_non_fwd

Overview:
Stall/flush controller for the 5-stage non-forwarding pipeline (IF, ID, EX, MEM, WB; branches resolve in EX).
- Tracks in-flight register writes with per-register pending counters.
- Stalls ID on RAW hazards until the producer has left WB. The regfile has no write-through bypass.
- Flushes IF/ID and ID/EX on misprediction.
- Exports stall and flush performance counters plus a deadlock watchdog for the testbench scoreboard.

Parameters:
NUM_REGS, 32, architectural registers; x0 is never pending.
CNT_W, 2, pending-counter width; at most 3 writers are in flight past ID.
PERF_W, 32, width of the performance counters.
STALL_TIMEOUT, 16, consecutive stall cycles before o_deadlock is raised.

Ports:
i_clk  in  1  clock; all state updates on posedge.
i_reset  in  1  asynchronous, active-low reset.
i_id_vld  in  1  ID holds a valid instruction.
i_id_rs1_addr  in  5  ID source register 1.
i_id_rs1_use  in  1  instruction reads rs1.
i_id_rs2_addr  in  5  ID source register 2.
i_id_rs2_use  in  1  instruction reads rs2.
i_id_rd_addr  in  5  ID destination register.
i_id_rd_wren  in  1  instruction writes rd.
i_wb_vld  in  1  WB holds a valid instruction.
i_wb_rd_addr  in  5  WB destination register.
i_wb_rd_wren  in  1  WB writes rd this cycle.
i_ex_mispred  in  1  EX redirect (branch/jump mispredict).
o_pc_en  out  1  PC update enable.
o_if_id_en  out  1  IF/ID register enable.
o_if_id_flush  out  1  clear IF/ID to bubble.
o_id_ex_flush  out  1  insert bubble into ID/EX.
o_id_issue  out  1  ID instruction advances to EX this cycle.
o_state  out  2  FSM state, for debug.
o_stall_cnt  out  PERF_W  total RAW stall cycles.
o_flush_cnt  out  PERF_W  total mispredict flushes.
o_deadlock  out  1  sticky watchdog flag.

Behaviour:
- Reset (i_reset=0, async):
  - All pending counters = 0; o_state = RUN.
  - o_stall_cnt = 0, o_flush_cnt = 0, o_deadlock = 0, stall-run counter = 0.
  - Control outputs forced: o_pc_en=0, o_if_id_en=0, o_if_id_flush=1, o_id_ex_flush=1, o_id_issue=0.
  - Reset mid-stall discards every pending entry.
- Pending state: pend[r] is CNT_W bits.
  - Increments when o_id_issue & i_id_rd_wren & rd!=0.
  - Decrements when i_wb_vld & i_wb_rd_wren & wb_rd!=0.
  - Increment and decrement on the same register in the same cycle: net 0.
  - pend[0] is held at 0.
  - Increment at max or decrement at 0 is illegal; the bench flags it with an assertion.
- Hazard (combinational, uses registered pend, no same-cycle WB bypass):
  - hazard = i_id_vld & ((rs1_use & rs1!=0 & pend[rs1]!=0) | (rs2_use & rs2!=0 & pend[rs2]!=0)).
- Control priority: mispredict > hazard > normal.
  - Mispredict: o_pc_en=1, o_if_id_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_id_issue=0. Pend is not incremented for the killed ID instruction. o_flush_cnt+1.
  - Hazard (no mispredict): o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_id_issue=0. o_stall_cnt+1.
  - Normal: o_pc_en=1, o_if_id_en=1, both flushes 0, o_id_issue=i_id_vld.
- Latency: a dependent instruction directly behind its producer stalls exactly 3 cycles (producer in EX, MEM, WB), then issues on the 4th cycle.
- FSM (o_state):
  - RUN=0, STALL=1, FLUSH=2.
  - Next state = FLUSH on mispredict, else STALL on hazard, else RUN.
  - FLUSH lasts one cycle unless mispredict repeats.
- Watchdog:
  - Stall-run counter increments in every STALL cycle and clears on any non-STALL cycle.
  - When it reaches STALL_TIMEOUT, o_deadlock goes 1 and stays 1 until reset.
- Perf counters wrap modulo 2^PERF_W.

Decomposition:
- Package hazard_pkg: state enum (RUN, STALL, FLUSH), REG_ADDR_W=5, the default parameter constants, and the control-bundle struct {pc_en, if_id_en, if_id_flush, id_ex_flush, id_issue}.
- One sub-module, reg_pend_tracker: the pending-counter array with inc/dec ports and two combinational read ports returning "busy".
- hazard_ctrl_non_fwd itself holds the FSM, priority logic, perf counters and watchdog.

Test Plan:
1. Back-to-back RAW: issue "addi x5", then "add x6,x5,x0" → o_id_issue=0 for exactly 3 cycles, issues on cycle 4, o_stall_cnt=3, o_state STALL for 3 cycles.
2. x0 and unused sources: producer writes x0, consumer reads x0; also rs2_use=0 with rs2 pending → no stall, o_stall_cnt=0.
3. Mispredict during stall: consumer stalled on x5, i_ex_mispred=1 → both flushes=1, o_pc_en=1, o_id_issue=0, pend[x5] unchanged, o_flush_cnt=1, o_state=FLUSH next cycle.
4. WAW: two writers of x7 issued, then a reader → pend[x7]=2; reader stalls until the second WB retires; same-cycle ID-issue and WB of x7 leaves pend[x7] unchanged.
5. Watchdog: pend[x9]=1, WB held idle, reader of x9 in ID → o_deadlock=1 after 16 stall cycles and stays 1 after the stall clears.
6. Reset mid-stall: deassert i_reset during a stall → all counters 0, o_deadlock=0, the stalled reader issues one cycle after reset release.
